// File: rtl/phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : phase_scheduler
// Description : Two-group intersection sequencer. Holds the phase FSM, the
//               per-phase seconds countdown, the duration configuration
//               registers and the round-robin priority-request arbiter.
//               Advances on 1 s ticks; keys arrive as one-cycle pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1      system clock
//   rst         in   1      synchronous reset, active-high
//   tick_1s     in   1      one-cycle pulse, once per second
//   mode        in   2      00 run, 01 night, 1x hold
//   peak        in   1      main-road peak hour, sampled when G1 loads
//   req_g1      in   1      one-cycle priority request, group 1
//   req_g2      in   1      one-cycle priority request, group 2
//   cfg_we      in   1      config write strobe
//   cfg_addr    in   3      0 G1, 1 G1L, 2 G2, 3 G2L, 4 YEL, 5 PRE
//   cfg_wdata   in   CNT_W  duration in seconds
//   phase       out  4      current phase code
//   remaining   out  CNT_W  seconds left in current phase
//   lamps       out  12     {R1,Y1,G1,R1L,Y1L,G1L,R2,Y2,G2,R2L,Y2L,G2L}
//   phase_start out  1      one-cycle pulse on every phase entry
//   req_ack     out  1      one-cycle pulse on priority grant
// ============================================================================
module phase_scheduler #(
   parameter int CNT_W   = 11,
   parameter int G1_DEF  = 30,
   parameter int G1L_DEF = 15,
   parameter int G2_DEF  = 30,
   parameter int G2L_DEF = 15,
   parameter int YEL_DEF = 5,
   parameter int PRE_DEF = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_1s,
   input  logic [1:0]       mode,
   input  logic             peak,
   input  logic             req_g1,
   input  logic             req_g2,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_wdata,
   output logic [3:0]       phase,
   output logic [CNT_W-1:0] remaining,
   output logic [11:0]      lamps,
   output logic             phase_start,
   output logic             req_ack
);

   typedef enum logic [3:0] {
      PH_NIGHT = 4'd0,
      PH_G1    = 4'd1,
      PH_G1_Y  = 4'd2,
      PH_G1L   = 4'd3,
      PH_G1L_Y = 4'd4,
      PH_G2    = 4'd5,
      PH_G2_Y  = 4'd6,
      PH_G2L   = 4'd7,
      PH_G2L_Y = 4'd8,
      PH_PRE1  = 4'd9,
      PH_PRE2  = 4'd10
   } phase_t;

   localparam logic [1:0]       MODE_RUN   = 2'b00;
   localparam logic [1:0]       MODE_NIGHT = 2'b01;
   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [11:0]      LAMPS_NIGHT = 12'b010_010_010_010;

   phase_t           state_q, state_d;
   logic [CNT_W-1:0] rem_d;
   logic             start_d, ack_d;
   logic             load;
   logic [CNT_W-1:0] load_dur;
   logic             pend_g1, pend_g2;
   logic             clr_g1, clr_g2;
   logic             rr_g2, rr_d;      // 0: group 1 wins a tie, 1: group 2 wins
   logic [CNT_W-1:0] dur_g1, dur_g1l, dur_g2, dur_g2l, dur_yel, dur_pre;
   logic [CNT_W:0]   g1_dbl;
   logic [CNT_W-1:0] g1_peak;
   logic             elig_g1, elig_g2, grant_g1, grant_g2;

   // Green of the same group and pre-emption phases are never eligible; a
   // request arriving this cycle counts immediately so the grant lands on
   // the very next edge.
   assign elig_g1  = (mode == MODE_RUN) && (pend_g1 || req_g1) &&
                     (state_q != PH_PRE1) && (state_q != PH_PRE2) && (state_q != PH_G1);
   assign elig_g2  = (mode == MODE_RUN) && (pend_g2 || req_g2) &&
                     (state_q != PH_PRE1) && (state_q != PH_PRE2) && (state_q != PH_G2);
   assign grant_g1 = elig_g1 && (!elig_g2 || !rr_g2);
   assign grant_g2 = elig_g2 && !grant_g1;

   // Peak-hour main green is doubled, clamped to the counter range.
   assign g1_dbl  = {dur_g1, 1'b0};
   assign g1_peak = g1_dbl[CNT_W] ? CNT_MAX : g1_dbl[CNT_W-1:0];

   assign phase = state_q;

   function automatic phase_t next_run(input phase_t p);
      case (p)
         PH_G1:    next_run = PH_G1_Y;
         PH_G1_Y:  next_run = PH_G1L;
         PH_G1L:   next_run = PH_G1L_Y;
         PH_G1L_Y: next_run = PH_G2;
         PH_G2:    next_run = PH_G2_Y;
         PH_G2_Y:  next_run = PH_G2L;
         PH_G2L:   next_run = PH_G2L_Y;
         PH_PRE2:  next_run = PH_G2;
         default:  next_run = PH_G1;
      endcase
   endfunction

   function automatic logic [11:0] lamp_of(input phase_t p);
      case (p)
         PH_G1:    lamp_of = 12'b001_100_100_100;
         PH_G1_Y:  lamp_of = 12'b010_100_100_100;
         PH_G1L:   lamp_of = 12'b100_001_100_100;
         PH_G1L_Y: lamp_of = 12'b100_010_100_100;
         PH_G2:    lamp_of = 12'b100_100_001_100;
         PH_G2_Y:  lamp_of = 12'b100_100_010_100;
         PH_G2L:   lamp_of = 12'b100_100_100_001;
         PH_G2L_Y: lamp_of = 12'b100_100_100_010;
         PH_PRE1:  lamp_of = 12'b100_100_010_100;
         PH_PRE2:  lamp_of = 12'b010_100_100_100;
         default:  lamp_of = LAMPS_NIGHT;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      rem_d    = remaining;
      load     = 1'b0;
      ack_d    = 1'b0;
      rr_d     = rr_g2;
      clr_g1   = 1'b0;
      clr_g2   = 1'b0;
      load_dur = CNT_ZERO;

      if (state_q > PH_PRE2) begin
         state_d = PH_NIGHT;
         rem_d   = CNT_ZERO;
      end else if (mode == MODE_NIGHT) begin
         state_d = PH_NIGHT;
         rem_d   = CNT_ZERO;
         clr_g1  = 1'b1;
         clr_g2  = 1'b1;
      end else if (mode == MODE_RUN) begin
         // A grant outranks a tick expiry arriving in the same cycle.
         if (grant_g1) begin
            state_d = PH_PRE1;
            load    = 1'b1;
            ack_d   = 1'b1;
            clr_g1  = 1'b1;
            rr_d    = ~rr_g2;
         end else if (grant_g2) begin
            state_d = PH_PRE2;
            load    = 1'b1;
            ack_d   = 1'b1;
            clr_g2  = 1'b1;
            rr_d    = ~rr_g2;
         end else if (state_q == PH_NIGHT) begin
            state_d = PH_G1;
            load    = 1'b1;
         end else if (tick_1s) begin
            if (remaining > CNT_ONE) begin
               rem_d = remaining - CNT_ONE;
            end else begin
               state_d = next_run(state_q);
               load    = 1'b1;
            end
         end
      end

      case (state_d)
         PH_G1:            load_dur = peak ? g1_peak : dur_g1;
         PH_G1L:           load_dur = dur_g1l;
         PH_G2:            load_dur = dur_g2;
         PH_G2L:           load_dur = dur_g2l;
         PH_PRE1, PH_PRE2: load_dur = dur_pre;
         default:          load_dur = dur_yel;
      endcase

      if (load) begin
         // A zero duration still has to last one tick.
         rem_d = (load_dur == CNT_ZERO) ? CNT_ONE : load_dur;
         if (state_d == PH_G1) clr_g1 = 1'b1;
         if (state_d == PH_G2) clr_g2 = 1'b1;
      end

      start_d = load || ((state_d == PH_NIGHT) && (state_q != PH_NIGHT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PH_NIGHT;
         remaining   <= CNT_ZERO;
         lamps       <= LAMPS_NIGHT;
         phase_start <= 1'b0;
         req_ack     <= 1'b0;
         pend_g1     <= 1'b0;
         pend_g2     <= 1'b0;
         rr_g2       <= 1'b0;
         dur_g1      <= CNT_W'(G1_DEF);
         dur_g1l     <= CNT_W'(G1L_DEF);
         dur_g2      <= CNT_W'(G2_DEF);
         dur_g2l     <= CNT_W'(G2L_DEF);
         dur_yel     <= CNT_W'(YEL_DEF);
         dur_pre     <= CNT_W'(PRE_DEF);
      end else begin
         state_q     <= state_d;
         remaining   <= rem_d;
         lamps       <= lamp_of(state_d);
         phase_start <= start_d;
         req_ack     <= ack_d;
         // A request in the same cycle as a clear re-arms the pending flag.
         pend_g1     <= (pend_g1 & ~clr_g1) | req_g1;
         pend_g2     <= (pend_g2 & ~clr_g2) | req_g2;
         rr_g2       <= rr_d;
         if (cfg_we) begin
            case (cfg_addr)
               3'd0:    dur_g1  <= cfg_wdata;
               3'd1:    dur_g1l <= cfg_wdata;
               3'd2:    dur_g2  <= cfg_wdata;
               3'd3:    dur_g2l <= cfg_wdata;
               3'd4:    dur_yel <= cfg_wdata;
               3'd5:    dur_pre <= cfg_wdata;
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
